aes_key_expand_128: RTL



---
 rtl/aes_key_expand_128.sv | 126 ++++++++++++
 1 files changed

// File: rtl/aes_key_expand_128.sv
// Iterative AES-128 key schedule: accepts one cipher key, produces one round key per
// clock into an 11-entry register file that the cipher core reads by round index.
module aes_key_expand_128 #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic         keys_valid,
    output logic         busy
);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    // Byte 0x00 sits in the top byte, so entry x lives at bit offset 8*(255-x) = {~x, 3'b000}.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    state_t         r_state;
    logic [3:0]     r_round;
    logic [127:0]   r_cur;
    logic [127:0]   r_rk [0:NUM_ROUNDS];
    logic           r_keys_valid;
    logic           r_busy;

    logic [31:0]    w_temp;
    logic [31:0]    w_w0, w_w1, w_w2, w_w3;
    logic [127:0]   w_next;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // r_cur mirrors rk[r-1], so the round logic never goes through the read mux.
    always_comb begin
        w_temp = sub_word({r_cur[23:0], r_cur[31:24]}) ^ {rcon(r_round), 24'h0};
        w_w0   = r_cur[127:96] ^ w_temp;
        w_w1   = r_cur[95:64]  ^ w_w0;
        w_w2   = r_cur[63:32]  ^ w_w1;
        w_w3   = r_cur[31:0]   ^ w_w2;
        w_next = {w_w0, w_w1, w_w2, w_w3};
    end

    // NOTE: the round-key file is reset explicitly because consumers observe it
    // directly and must read zeros after reset, so it cannot map to a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_round      <= '0;
            r_cur        <= '0;
            r_keys_valid <= 1'b0;
            r_busy       <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) r_rk[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            case (r_state)
                IDLE, DONE: begin
                    if (key_valid) begin
                        r_rk[0]      <= key_in;
                        r_cur        <= key_in;
                        r_round      <= 4'd1;
                        r_state      <= EXPAND;
                        r_keys_valid <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                EXPAND: begin
                    r_rk[r_round] <= w_next;
                    r_cur         <= w_next;
                    r_round       <= r_round + 4'd1;
                    if (r_round == LAST_ROUND) begin
                        r_state      <= DONE;
                        r_keys_valid <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: rk_out gets a default before the conditional so no latch is inferred.
    always_comb begin
        rk_out = '0;
        if (rk_idx <= LAST_ROUND) rk_out = r_rk[rk_idx];
    end

    assign key_ready  = (r_state != EXPAND);
    assign keys_valid = r_keys_valid;
    assign busy       = r_busy;

endmodule
